// File: rtl/lcd_mode_scheduler.sv
// lcd_mode_scheduler: HD44780 power-on init plus a continuous 32-character
// refresh, with frame-aligned mode switching and one-shot key routing.
module lcd_mode_scheduler #(
    parameter int N_MODES   = 4,
    parameter int FETCH_CYC = 3,
    parameter int EN_CYC    = 12,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 80000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_key,
    input  logic [3:0]           sw_in,
    input  logic [8*N_MODES-1:0] char_bus,
    output logic [4:0]           index,
    output logic [1:0]           mode_sel,
    output logic [4*N_MODES-1:0] sw_route,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_data,
    output logic                 init_done,
    output logic                 frame_done
);
    localparam int M1   = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
    localparam int M2   = (EN_CYC > FETCH_CYC) ? EN_CYC : FETCH_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_SETUP, S_EN, S_HOLD, S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SRC_INIT, SRC_ADDR, SRC_DATA
    } src_t;

    state_t               state, state_nx;
    src_t                 src, src_nx;
    logic [CW-1:0]        cnt, cnt_nx, lim;
    logic [1:0]           step, step_nx, msel_nx;
    logic [4:0]           idx_nx;
    logic [7:0]           data_nx;
    logic                 rs_nx, e_nx, done_nx, frame_nx;
    logic                 pend, pend_nx, key_prev, key_edge, last;
    logic [3:0]           sw_prev;
    logic [4*N_MODES-1:0] route_nx;

    assign lcd_rw   = 1'b0;
    assign key_edge = mode_key & ~key_prev & init_done;
    assign last     = (cnt == lim - CW'(1));

    always_comb begin
        lim = CW'(EN_CYC);
        unique case (state)
            S_FETCH: lim = CW'(FETCH_CYC);
            S_WAIT:  lim = (src == SRC_INIT && step == 2'd2) ?
                           CW'(CLR_CYC) : CW'(CMD_CYC);
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = last ? '0 : cnt + CW'(1);
        src_nx   = src;
        step_nx  = step;
        idx_nx   = index;
        data_nx  = lcd_data;
        rs_nx    = lcd_rs;
        e_nx     = lcd_e;
        done_nx  = init_done;
        frame_nx = 1'b0;
        msel_nx  = mode_sel;
        pend_nx  = pend | key_edge;
        route_nx = '0;
        if (sw_in != 4'd0 && sw_prev == 4'd0)
            route_nx[4*mode_sel +: 4] = sw_in;
        unique case (state)
            S_INIT: begin
                state_nx = S_SETUP;
                cnt_nx   = '0;
                src_nx   = SRC_INIT;
                step_nx  = 2'd0;
                data_nx  = 8'h38;
                rs_nx    = 1'b0;
            end
            S_FETCH: if (last) begin
                state_nx = S_SETUP;
                src_nx   = SRC_DATA;
                data_nx  = char_bus[8*mode_sel +: 8];
                rs_nx    = 1'b1;
            end
            S_SETUP: if (last) begin
                state_nx = S_EN;
                e_nx     = 1'b1;
            end
            S_EN: if (last) begin
                state_nx = S_HOLD;
                e_nx     = 1'b0;
            end
            S_HOLD: if (last) state_nx = S_WAIT;
            S_WAIT: if (last) begin
                // dispatch happens here so ADDR/NEXT cost no extra clocks
                state_nx = S_SETUP;
                unique case (src)
                    SRC_INIT: begin
                        rs_nx   = 1'b0;
                        step_nx = step + 2'd1;
                        unique case (step)
                            2'd0: data_nx = 8'h0C;
                            2'd1: data_nx = 8'h01;
                            2'd2: data_nx = 8'h06;
                            default: begin
                                done_nx = 1'b1;
                                src_nx  = SRC_ADDR;
                                data_nx = 8'h80;
                            end
                        endcase
                    end
                    SRC_ADDR: state_nx = S_FETCH;
                    default: begin
                        unique case (1'b1)
                            (index == 5'd31): begin
                                frame_nx = 1'b1;
                                idx_nx   = 5'd0;
                                src_nx   = SRC_ADDR;
                                data_nx  = 8'h80;
                                rs_nx    = 1'b0;
                                if (pend) begin
                                    msel_nx = (mode_sel == 2'(N_MODES - 1)) ?
                                              2'd0 : mode_sel + 2'd1;
                                    pend_nx = key_edge;
                                end
                            end
                            (index == 5'd15): begin
                                idx_nx  = 5'd16;
                                src_nx  = SRC_ADDR;
                                data_nx = 8'hC0;
                                rs_nx   = 1'b0;
                            end
                            default: begin
                                idx_nx   = index + 5'd1;
                                state_nx = S_FETCH;
                            end
                        endcase
                    end
                endcase
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT;
            src        <= SRC_INIT;
            cnt        <= '0;
            step       <= 2'd0;
            index      <= 5'd0;
            mode_sel   <= 2'd0;
            sw_route   <= '0;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_data   <= 8'd0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            pend       <= 1'b0;
            key_prev   <= 1'b0;
            sw_prev    <= 4'd0;
        end else begin
            state      <= state_nx;
            src        <= src_nx;
            cnt        <= cnt_nx;
            step       <= step_nx;
            index      <= idx_nx;
            mode_sel   <= msel_nx;
            sw_route   <= route_nx;
            lcd_rs     <= rs_nx;
            lcd_e      <= e_nx;
            lcd_data   <= data_nx;
            init_done  <= done_nx;
            frame_done <= frame_nx;
            pend       <= pend_nx;
            key_prev   <= mode_key;
            sw_prev    <= sw_in;
        end
    end
endmodule

// File: tb/tb_lcd_mode_scheduler.sv
// tb_lcd_mode_scheduler: scoreboard of expected LCD writes plus
// mode-switch, key-routing and reset checks at reduced timing.
module tb_lcd_mode_scheduler;
    localparam int NM = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          mode_key = 1'b0;
    logic [3:0]    sw_in    = 4'd0;
    logic [8*NM-1:0] char_bus = '0;
    logic [4:0]    index;
    logic [1:0]    mode_sel;
    logic [4*NM-1:0] sw_route;
    logic          lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0]    lcd_data;
    logic [35:0]   outs;

    int   checks = 0, failures = 0;
    logic [8:0] sb[$];
    int   cyc = 0, last_rise = 0, wr_n = 0, fwr = 0;
    bit   first = 1'b1, prev_e = 1'b0;
    logic [8:0] held = '0, exp_wr;
    int   rt_cnt[NM];
    logic [3:0] rt_val[NM];

    lcd_mode_scheduler #(
        .N_MODES(NM), .FETCH_CYC(3), .EN_CYC(2),
        .CMD_CYC(5), .CLR_CYC(20)
    ) dut (
        .clk(clk), .rst(rst), .mode_key(mode_key), .sw_in(sw_in),
        .char_bus(char_bus), .index(index), .mode_sel(mode_sel),
        .sw_route(sw_route), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data), .init_done(init_done),
        .frame_done(frame_done)
    );

    assign outs = {index, mode_sel, sw_route, lcd_rs, lcd_rw, lcd_e,
                   lcd_data, init_done, frame_done};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] char_of(input int m, input int i);
        return 8'(32'h41 + i + 64 * m);
    endfunction

    // mode blocks with a registered character output
    always @(posedge clk)
        for (int m = 0; m < NM; m++)
            char_bus[8*m +: 8] <= char_of(m, int'(index));

    task automatic push_init();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
    endtask

    task automatic push_frame(input int m);
        sb.push_back({1'b0, 8'h80});
        for (int i = 0; i < 32; i++) begin
            if (i == 16) sb.push_back({1'b0, 8'hC0});
            sb.push_back({1'b1, char_of(m, i)});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int s = 0; s < NM; s++)
            if (sw_route[4*s +: 4] != 4'd0) begin
                rt_cnt[s]++;
                rt_val[s] = sw_route[4*s +: 4];
            end
        if (!rst) begin
            prev_e = 1'b0;
            wr_n   = 0;
            fwr    = 0;
            first  = 1'b1;
        end else begin
            if (lcd_e && !prev_e) begin
                held = {lcd_rs, lcd_data};
                if (sb.size() == 0) begin
                    check_eq("sb_extra", sb.size(), 1);
                end else begin
                    exp_wr = sb.pop_front();
                    check_eq("lcd_wr", {lcd_rs, lcd_data}, exp_wr);
                end
                if (wr_n == 1) check_eq("gap_cmd", cyc - last_rise, 11);
                if (wr_n == 3) check_eq("gap_clr", cyc - last_rise, 26);
                if (wr_n == 3) check_eq("init_pre", init_done, 0);
                if (wr_n == 4) check_eq("init_post", init_done, 1);
                last_rise = cyc;
                wr_n++;
                fwr++;
            end else if (lcd_e) begin
                check_eq("e_stable", {lcd_rs, lcd_data}, held);
            end
            if (frame_done) begin
                check_eq("frame_len", fwr, first ? 38 : 34);
                fwr   = 0;
                first = 1'b0;
            end
            prev_e = lcd_e;
        end
    end

    task automatic wait_frame(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < budget);
        check_eq("frame_seen", frame_done, 1);
    endtask

    task automatic wait_idx(input logic [4:0] v, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (index != v && n < budget);
        check_eq("idx_seen", index, v);
    endtask

    task automatic key_pulse();
        @(posedge clk); #1 mode_key = 1'b1;
        repeat (3) @(posedge clk);
        #1 mode_key = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        for (int s = 0; s < NM; s++) begin
            rt_cnt[s] = 0;
            rt_val[s] = 4'd0;
        end
        #1 rst = 1'b0;
        #1 check_eq("reset_outs", outs, 0);
        repeat (3) @(negedge clk);
        push_init();
        push_frame(0);
        rst = 1'b1;

        wait_idx(5'd5, 2000);
        key_pulse();
        key_pulse();
        push_frame(1);
        wait_frame(1500);
        check_eq("mode_2keys", mode_sel, 1);

        key_pulse();
        push_frame(2);
        wait_frame(1500);
        check_eq("mode_2", mode_sel, 2);

        @(posedge clk); #1 sw_in = 4'b0010;
        @(negedge clk); check_eq("route_pre", sw_route, 0);
        @(negedge clk); check_eq("route_pulse", sw_route, 16'h0200);
        repeat (50) @(posedge clk);
        #1 sw_in = 4'b0100;
        repeat (10) @(posedge clk);
        #1 sw_in = 4'b0000;
        repeat (5) @(posedge clk);
        check_eq("route_cnt2", rt_cnt[2], 1);
        check_eq("route_val2", rt_val[2], 4'b0010);
        check_eq("route_other", rt_cnt[0] + rt_cnt[1] + rt_cnt[3], 0);

        key_pulse();
        push_frame(3);
        wait_frame(1500);
        check_eq("mode_3", mode_sel, 3);

        key_pulse();
        push_frame(0);
        wait_frame(1500);
        check_eq("mode_wrap", mode_sel, 0);

        wait_idx(5'd20, 1500);
        n = 0;
        while (!lcd_e && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("e_at_20", lcd_e, 1);
        #2 rst = 1'b0;
        #1 check_eq("rst_outs", outs, 0);
        sb.delete();
        push_init();
        push_frame(0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_eq("idx_restart", index, 0);
        wait_frame(2000);
        check_eq("sb_drained", sb.size(), 0);
        check_eq("mode_post_rst", mode_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
